// File: rtl/snake_engine_v2.sv
// snake_engine_v2
//   Snake body engine. The body is a circular segment buffer; each accepted `step`
//   computes the next head, checks walls, scans the body for self-collision (one
//   segment per cycle), then commits the move. A second read port serves the renderer.
//
//   Optional feature macro: SNAKE_WRAP_EN -- when defined, the head wraps around the
//   grid edges instead of dying on a wall; when undefined, no wrap logic is built.
//
//   Ports:
//     clk, rst_n                       clock, asynchronous active-low reset
//     step                             move request pulse (accepted only when idle)
//     dir                              00 right, 01 left, 10 up, 11 down
//     fruit_x_cell, fruit_y_cell       fruit cell, sampled with step
//     rd_idx                           body read index (0 = head)
//     rd_x, rd_y, rd_valid             registered read data, valid = rd_idx < snake_len
//     snake_head_x_cell/_y_cell        current head
//     snake_len                        current length
//     busy                             move in progress
//     ate_fruit                        one-cycle pulse when a growing move commits
//     game_over                        sticky until reset
module snake_engine_v2 #(
   parameter int unsigned H_CELLS  = 40,
   parameter int unsigned V_CELLS  = 30,
   parameter int unsigned MAX_LEN  = 64,
   parameter int unsigned INIT_LEN = 3,
   parameter int unsigned INIT_X   = 20,
   parameter int unsigned INIT_Y   = 15,
   parameter int unsigned COORD_W  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               step,
   input  logic [1:0]         dir,
   input  logic [COORD_W-1:0] fruit_x_cell,
   input  logic [COORD_W-1:0] fruit_y_cell,
   input  logic [7:0]         rd_idx,
   output logic [COORD_W-1:0] rd_x,
   output logic [COORD_W-1:0] rd_y,
   output logic               rd_valid,
   output logic [COORD_W-1:0] snake_head_x_cell,
   output logic [COORD_W-1:0] snake_head_y_cell,
   output logic [7:0]         snake_len,
   output logic               busy,
   output logic               ate_fruit,
   output logic               game_over
);

   localparam int unsigned PtrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_LEN - 1);

   // One extra signed bit so a step off the low edge shows up as -1.
   typedef logic signed [COORD_W:0] scoord_t;
   localparam scoord_t XLim = scoord_t'(H_CELLS);
   localparam scoord_t YLim = scoord_t'(V_CELLS);

   typedef enum logic [2:0] {StIdle, StCalc, StScan, StCommit, StDead} state_e;

   state_e             state_q;
   logic [COORD_W-1:0] seg_x_q [MAX_LEN];
   logic [COORD_W-1:0] seg_y_q [MAX_LEN];
   logic [PtrW-1:0]    head_ptr_q, scan_ptr_q;
   logic [COORD_W-1:0] head_x_q, head_y_q, fruit_x_q, fruit_y_q, nh_x_q, nh_y_q;
   logic [7:0]         len_q, scan_cnt_q, scan_k_q;
   logic [1:0]         heading_q;
   logic               grow_q, wall_q, busy_q, ate_q, over_q;
   logic [COORD_W-1:0] rd_x_q, rd_y_q;
   logic               rd_valid_q;

   logic [1:0]      heading_sel;
   scoord_t         nh_x, nh_y;
   logic            wall_c, grow_c, scan_hit;
   logic [7:0]      k_c;
   logic [PtrW-1:0] head_ptr_nxt, scan_ptr_nxt, rd_ptr;
   logic [8:0]      rd_diff;

   assign head_ptr_nxt = (head_ptr_q == PtrLast) ? '0 : head_ptr_q + 1'b1;
   assign scan_ptr_nxt = (scan_ptr_q == '0) ? PtrLast : scan_ptr_q - 1'b1;

   always_comb begin
      // A direction opposite the current heading is ignored.
      heading_sel = ((dir[1] == heading_q[1]) && (dir[0] != heading_q[0])) ? heading_q : dir;

      nh_x = scoord_t'({1'b0, head_x_q});
      nh_y = scoord_t'({1'b0, head_y_q});
      unique case (heading_q)
         2'b00:   nh_x = nh_x + scoord_t'(1);
         2'b01:   nh_x = nh_x - scoord_t'(1);
         2'b10:   nh_y = nh_y - scoord_t'(1);
         default: nh_y = nh_y + scoord_t'(1);
      endcase

`ifdef SNAKE_WRAP_EN
      if (nh_x[COORD_W])    nh_x = XLim - scoord_t'(1);
      else if (nh_x >= XLim) nh_x = '0;
      if (nh_y[COORD_W])    nh_y = YLim - scoord_t'(1);
      else if (nh_y >= YLim) nh_y = '0;
      wall_c = 1'b0;
`else
      wall_c = nh_x[COORD_W] || (nh_x >= XLim) || nh_y[COORD_W] || (nh_y >= YLim);
`endif

      grow_c = (nh_x == scoord_t'({1'b0, fruit_x_q})) && (nh_y == scoord_t'({1'b0, fruit_y_q}));
      // When not growing the tail moves out of the way, so it is not scanned.
      k_c = grow_c ? len_q : len_q - 8'd1;

      scan_hit = (seg_x_q[scan_ptr_q] == nh_x_q) && (seg_y_q[scan_ptr_q] == nh_y_q);

      rd_diff = 9'(head_ptr_q) - {1'b0, rd_idx};
      if (rd_diff[8]) rd_diff = rd_diff + 9'(MAX_LEN);
      rd_ptr = (rd_idx >= 8'(MAX_LEN)) ? '0 : rd_diff[PtrW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (i < int'(INIT_LEN)) begin
               seg_x_q[i] <= COORD_W'(int'(INIT_X) - int'(INIT_LEN) + 1 + i);
               seg_y_q[i] <= COORD_W'(INIT_Y);
            end else begin
               seg_x_q[i] <= '0;
               seg_y_q[i] <= '0;
            end
         end
         state_q    <= StIdle;
         head_ptr_q <= PtrW'(INIT_LEN - 1);
         scan_ptr_q <= '0;
         head_x_q   <= COORD_W'(INIT_X);
         head_y_q   <= COORD_W'(INIT_Y);
         fruit_x_q  <= '0;
         fruit_y_q  <= '0;
         nh_x_q     <= '0;
         nh_y_q     <= '0;
         len_q      <= 8'(INIT_LEN);
         scan_cnt_q <= '0;
         scan_k_q   <= '0;
         heading_q  <= 2'b00;
         grow_q     <= 1'b0;
         wall_q     <= 1'b0;
         busy_q     <= 1'b0;
         ate_q      <= 1'b0;
         over_q     <= 1'b0;
         rd_x_q     <= '0;
         rd_y_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         ate_q      <= 1'b0;
         rd_x_q     <= seg_x_q[rd_ptr];
         rd_y_q     <= seg_y_q[rd_ptr];
         rd_valid_q <= (rd_idx < len_q);

         unique case (state_q)
            StIdle: begin
               if (step && !over_q) begin
                  heading_q <= heading_sel;
                  fruit_x_q <= fruit_x_cell;
                  fruit_y_q <= fruit_y_cell;
                  busy_q    <= 1'b1;
                  state_q   <= StCalc;
               end
            end
            StCalc: begin
               nh_x_q     <= nh_x[COORD_W-1:0];
               nh_y_q     <= nh_y[COORD_W-1:0];
               grow_q     <= grow_c;
               wall_q     <= wall_c;
               scan_k_q   <= k_c;
               scan_cnt_q <= '0;
               scan_ptr_q <= head_ptr_q;
               state_q    <= (k_c == 8'd0) ? StCommit : StScan;
            end
            StScan: begin
               // The wall result is acted on in the first cycle after the head is computed.
               if (wall_q || scan_hit) begin
                  over_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StDead;
               end else if (scan_cnt_q == scan_k_q - 8'd1) begin
                  state_q <= StCommit;
               end else begin
                  scan_cnt_q <= scan_cnt_q + 8'd1;
                  scan_ptr_q <= scan_ptr_nxt;
               end
            end
            StCommit: begin
               if (wall_q) begin
                  over_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StDead;
               end else begin
                  // At full length this slot is the old tail, so it is overwritten.
                  seg_x_q[head_ptr_nxt] <= nh_x_q;
                  seg_y_q[head_ptr_nxt] <= nh_y_q;
                  head_ptr_q <= head_ptr_nxt;
                  head_x_q   <= nh_x_q;
                  head_y_q   <= nh_y_q;
                  if (grow_q && (len_q < 8'(MAX_LEN))) len_q <= len_q + 8'd1;
                  ate_q   <= grow_q;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            StDead: ;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rd_x              = rd_x_q;
   assign rd_y              = rd_y_q;
   assign rd_valid          = rd_valid_q;
   assign snake_head_x_cell = head_x_q;
   assign snake_head_y_cell = head_y_q;
   assign snake_len         = len_q;
   assign busy              = busy_q;
   assign ate_fruit         = ate_q;
   assign game_over         = over_q;

endmodule

// File: tb/tb_snake_engine_v2.sv
// Directed bench for snake_engine_v2: a default instance plus a MAX_LEN=8 instance
// used for the saturation scenario.
module tb_snake_engine_v2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       step = 1'b0, step8 = 1'b0;
   logic [1:0] dir = 2'b00;
   logic [5:0] fx = '0, fy = '0;
   logic [7:0] rd_idx = '0;

   logic [5:0] rd_x, rd_y, hx, hy, rd_x8, rd_y8, hx8, hy8;
   logic [7:0] len, len8;
   logic       rd_valid, busy, ate, go, rd_valid8, busy8, ate8, go8;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   snake_engine_v2 dut (
      .clk(clk), .rst_n(rst_n), .step(step), .dir(dir),
      .fruit_x_cell(fx), .fruit_y_cell(fy), .rd_idx(rd_idx),
      .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
      .snake_head_x_cell(hx), .snake_head_y_cell(hy), .snake_len(len),
      .busy(busy), .ate_fruit(ate), .game_over(go)
   );

   snake_engine_v2 #(.MAX_LEN(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .step(step8), .dir(dir),
      .fruit_x_cell(fx), .fruit_y_cell(fy), .rd_idx(rd_idx),
      .rd_x(rd_x8), .rd_y(rd_y8), .rd_valid(rd_valid8),
      .snake_head_x_cell(hx8), .snake_head_y_cell(hy8), .snake_len(len8),
      .busy(busy8), .ate_fruit(ate8), .game_over(go8)
   );

   // All stimulus tasks start and end on a falling edge.
   task automatic do_reset();
      rst_n = 1'b0; step = 1'b0; step8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse(input bit sel, input logic [1:0] d, input int x, input int y);
      dir = d; fx = 6'(x); fy = 6'(y);
      if (sel) step8 = 1'b1; else step = 1'b1;
      @(negedge clk);
      step = 1'b0; step8 = 1'b0;
   endtask

   // Counts falling edges with busy high; stops on the first one with busy low.
   task automatic wait_done(input bit sel, output int cycles);
      cycles = 0;
      for (int n = 0; n < 400; n++) begin
         if (!(sel ? busy8 : busy)) return;
         cycles++;
         @(negedge clk);
      end
      total++; bad++;
      $display("FAIL wait_done timeout got=busy_stuck want=busy_low");
   endtask

   task automatic move(input bit sel, input logic [1:0] d, input int x, input int y,
                       output int cycles);
      pulse(sel, d, x, y);
      wait_done(sel, cycles);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rd_idx = 8'd0;
      @(negedge clk);
      total++; if (hx !== 6'd20) begin bad++; $display("FAIL reset_hx got=%0d want=20", hx); end
      total++; if (hy !== 6'd15) begin bad++; $display("FAIL reset_hy got=%0d want=15", hy); end
      total++; if (len !== 8'd3) begin bad++; $display("FAIL reset_len got=%0d want=3", len); end
      total++; if ({busy, ate, go} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b want=000", {busy, ate, go}); end
      total++; if ({rd_valid, rd_x, rd_y} !== 13'd0) begin
         bad++; $display("FAIL reset_rd got=%b/%0d/%0d want=0/0/0", rd_valid, rd_x, rd_y); end
      rst_n = 1'b1; rd_idx = 8'd2;
      @(negedge clk);
      total++; if ({rd_valid, rd_x, rd_y} !== {1'b1, 6'd18, 6'd15}) begin
         bad++; $display("FAIL reset_rd2 got=%b/%0d/%0d want=1/18/15", rd_valid, rd_x, rd_y); end
      rd_idx = 8'd3;
      @(negedge clk);
      total++; if (rd_valid !== 1'b0) begin
         bad++; $display("FAIL reset_rd3_valid got=%b want=0", rd_valid); end
   endtask

   task automatic test_grow();
      int c;
      do_reset();
      move(0, 2'b00, 21, 15, c);
      total++; if (c != 5) begin bad++; $display("FAIL grow_busy got=%0d want=5", c); end
      total++; if (ate !== 1'b1) begin bad++; $display("FAIL grow_ate got=%b want=1", ate); end
      total++; if ({hx, hy} !== {6'd21, 6'd15}) begin
         bad++; $display("FAIL grow_head got=(%0d,%0d) want=(21,15)", hx, hy); end
      total++; if (len !== 8'd4) begin bad++; $display("FAIL grow_len got=%0d want=4", len); end
      rd_idx = 8'd3;
      @(negedge clk);
      total++; if (ate !== 1'b0) begin bad++; $display("FAIL grow_ate_pulse got=%b want=0", ate); end
      @(negedge clk);
      total++; if ({rd_valid, rd_x, rd_y} !== {1'b1, 6'd18, 6'd15}) begin
         bad++; $display("FAIL grow_tail got=%b/%0d/%0d want=1/18/15", rd_valid, rd_x, rd_y); end
   endtask

   task automatic test_reversal();
      int c;
      do_reset();
      move(0, 2'b01, 0, 0, c);
      total++; if ({hx, hy, len, go} !== {6'd21, 6'd15, 8'd3, 1'b0}) begin
         bad++; $display("FAIL reversal got=(%0d,%0d) len=%0d go=%b want=(21,15) len=3 go=0",
                         hx, hy, len, go); end
   endtask

   task automatic test_wall();
      int c;
      do_reset();
      for (int i = 0; i < 19; i++) move(0, 2'b00, 0, 0, c);
      total++; if ({hx, go} !== {6'd39, 1'b0}) begin
         bad++; $display("FAIL wall_approach got=%0d go=%b want=39 go=0", hx, go); end
      move(0, 2'b00, 0, 0, c);
`ifdef SNAKE_WRAP_EN
      total++; if ({hx, hy, go} !== {6'd0, 6'd15, 1'b0}) begin
         bad++; $display("FAIL wall_wrap got=(%0d,%0d) go=%b want=(0,15) go=0", hx, hy, go); end
`else
      total++; if (c != 2) begin bad++; $display("FAIL wall_busy got=%0d want=2", c); end
      total++; if ({hx, hy, go} !== {6'd39, 6'd15, 1'b1}) begin
         bad++; $display("FAIL wall_hit got=(%0d,%0d) go=%b want=(39,15) go=1", hx, hy, go); end
      move(0, 2'b11, 0, 0, c);
      total++; if ({hx, hy, len, go, busy} !== {6'd39, 6'd15, 8'd3, 1'b1, 1'b0} || c != 0) begin
         bad++; $display("FAIL wall_frozen got=(%0d,%0d) len=%0d go=%b busy=%0d want=(39,15) 3 1 0",
                         hx, hy, len, go, c); end
`endif
   endtask

   task automatic test_self_hit();
      int c;
      do_reset();
      move(0, 2'b00, 21, 15, c);
      move(0, 2'b00, 22, 15, c);
      total++; if (len !== 8'd5) begin bad++; $display("FAIL self_len got=%0d want=5", len); end
      move(0, 2'b11, 0, 0, c);
      move(0, 2'b01, 0, 0, c);
      total++; if (go !== 1'b0) begin bad++; $display("FAIL self_pre got=%b want=0", go); end
      move(0, 2'b10, 0, 0, c);
      total++; if (c != 5) begin bad++; $display("FAIL self_busy got=%0d want=5", c); end
      total++; if ({go, hx, hy, len} !== {1'b1, 6'd21, 6'd16, 8'd5}) begin
         bad++; $display("FAIL self_hit got=go%b (%0d,%0d) len=%0d want=go1 (21,16) len=5",
                         go, hx, hy, len); end
   endtask

   task automatic test_tail_vacate();
      int c;
      do_reset();
      move(0, 2'b00, 21, 15, c);
      move(0, 2'b00, 0, 0, c);
      move(0, 2'b11, 0, 0, c);
      move(0, 2'b01, 0, 0, c);
      move(0, 2'b10, 0, 0, c);
      total++; if (c != 5) begin bad++; $display("FAIL tail_busy got=%0d want=5", c); end
      total++; if ({go, hx, hy, len} !== {1'b0, 6'd21, 6'd15, 8'd4}) begin
         bad++; $display("FAIL tail_vacate got=go%b (%0d,%0d) len=%0d want=go0 (21,15) len=4",
                         go, hx, hy, len); end
      rd_idx = 8'd3;
      @(negedge clk);
      total++; if ({rd_x, rd_y} !== {6'd22, 6'd15}) begin
         bad++; $display("FAIL tail_rd got=(%0d,%0d) want=(22,15)", rd_x, rd_y); end
   endtask

   task automatic test_saturation();
      int c, exp_len, exp_cyc;
      do_reset();
      for (int m = 1; m <= 8; m++) begin
         exp_cyc = ((2 + m < 8) ? 2 + m : 8) + 2;
         exp_len = (3 + m < 8) ? 3 + m : 8;
         move(1, 2'b00, 20 + m, 15, c);
         total++; if (c != exp_cyc) begin
            bad++; $display("FAIL sat_busy move=%0d got=%0d want=%0d", m, c, exp_cyc); end
         total++; if ({ate8, len8, hx8, hy8} !== {1'b1, 8'(exp_len), 6'(20 + m), 6'd15}) begin
            bad++; $display("FAIL sat_move %0d got=ate%b len=%0d (%0d,%0d) want=ate1 len=%0d (%0d,15)",
                            m, ate8, len8, hx8, hy8, exp_len, 20 + m); end
      end
      rd_idx = 8'd7;
      @(negedge clk);
      total++; if ({rd_valid8, rd_x8, rd_y8, go8} !== {1'b1, 6'd21, 6'd15, 1'b0}) begin
         bad++; $display("FAIL sat_tail got=%b (%0d,%0d) go=%b want=1 (21,15) go=0",
                         rd_valid8, rd_x8, rd_y8, go8); end
      rd_idx = 8'd8;
      @(negedge clk);
      total++; if (rd_valid8 !== 1'b0) begin
         bad++; $display("FAIL sat_rd8 got=%b want=0", rd_valid8); end
   endtask

   task automatic test_reset_mid_scan();
      int c;
      do_reset();
      rd_idx = 8'd0;
      pulse(0, 2'b00, 21, 15);
      @(negedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
      rst_n = 1'b0;
      #1;
      total++; if ({hx, hy, len, busy, ate, go, rd_valid, rd_x} !==
                   {6'd20, 6'd15, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0}) begin
         bad++; $display("FAIL mid_reset got=(%0d,%0d) len=%0d b%b a%b g%b v%b x%0d want=(20,15) 3 0000 0",
                         hx, hy, len, busy, ate, go, rd_valid, rd_x); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      move(0, 2'b00, 21, 15, c);
      total++; if ({hx, hy, len, ate} !== {6'd21, 6'd15, 8'd4, 1'b1} || c != 5) begin
         bad++; $display("FAIL mid_after got=(%0d,%0d) len=%0d ate=%b busy=%0d want=(21,15) 4 1 5",
                         hx, hy, len, ate, c); end
   endtask

   initial begin
      test_reset();
      test_grow();
      test_reversal();
      test_wall();
      test_self_hit();
      test_tail_vacate();
      test_saturation();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
